// File: rtl/ubus_arb_pkg.sv
// Shared types and limits for the UBUS round-robin arbiter.
// Pure declarations: no logic, no latency, no flow control.
package ubus_arb_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        ARB  = 3'd1,
        NOOP = 3'd2,
        ADDR = 3'd3,
        DATA = 3'd4
    } arb_state_t;

    localparam int UBUS_ARB_MAX_MASTERS = 8;
    localparam int UBUS_ARB_WD_CNT_W    = 8;

endpackage

// File: rtl/ubus_rr_picker.sv
// Rotating-priority encoder: first set request above last_gnt (wrapping) wins.
// Purely combinational, zero latency; no backpressure.
module ubus_rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last_gnt,
    output logic             vld,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] pos;

    always_comb begin
        vld = 1'b0;
        gnt = '0;
        idx = '0;
        pos = '0;
        // Offset N wraps back to last_gnt itself, so the previous owner is considered last.
        for (int off = 1; off <= N; off++) begin
            pos = PTR_W'((int'(last_gnt) + off) % N);
            if (!vld && req[pos]) begin
                vld      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/ubus_rr_arbiter.sv
// Round-robin UBUS arbiter and ADDR/DATA phase sequencer; DATA watchdog under UBUS_ARB_WATCHDOG_EN.
// Grant one cycle after the ARB sample; no backpressure, slaves stretch DATA with ubus_bip/ubus_wait.
module ubus_rr_arbiter
    import ubus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_WAIT    = 16
) (
    input  logic                   ubus_clock,
    input  logic                   ubus_reset_n,
    input  logic [NUM_MASTERS-1:0] ubus_req,
    output logic [NUM_MASTERS-1:0] ubus_gnt,
    output logic                   ubus_start,
    output logic                   ubus_read,
    output logic                   ubus_write,
    input  logic                   ubus_bip,
    input  logic                   ubus_wait,
    input  logic                   ubus_error,
    output logic                   ubus_timeout
);

    localparam int PTR_W = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > UBUS_ARB_MAX_MASTERS) begin : g_bad_num_masters
        $error("ubus_rr_arbiter: NUM_MASTERS out of range");
    end
    if (MAX_WAIT < 2 || MAX_WAIT > (1 << UBUS_ARB_WD_CNT_W) - 1) begin : g_bad_max_wait
        $error("ubus_rr_arbiter: MAX_WAIT out of range");
    end

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]       last_gnt_q, last_gnt_d;
    logic                   start_q, start_d;
    logic                   noop_q, noop_d;

    logic                   pick_vld;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [PTR_W-1:0]       pick_idx;
    logic                   data_done;
    logic                   wd_expire;

    ubus_rr_picker #(
        .N     (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_picker (
        .req      (ubus_req),
        .last_gnt (last_gnt_q),
        .vld      (pick_vld),
        .gnt      (pick_gnt),
        .idx      (pick_idx)
    );

    assign data_done = ubus_error | (~ubus_bip & ~ubus_wait);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            INIT: state_d = ARB;
            ARB: begin
                if (pick_vld) begin
                    state_d    = ADDR;
                    gnt_d      = pick_gnt;
                    last_gnt_d = pick_idx;
                end else begin
                    state_d = NOOP;
                end
            end
            NOOP: state_d = ARB;
            ADDR: state_d = DATA;
            DATA: begin
                if (data_done || wd_expire) begin
                    state_d = ARB;
                end
            end
            default: state_d = INIT;
        endcase
        // Grant only survives while a transfer owns the bus.
        if (state_d != ADDR && state_d != DATA) begin
            gnt_d = '0;
        end
        start_d = (state_d == ARB);
        noop_d  = (state_d == NOOP);
    end

    always_ff @(posedge ubus_clock) begin
        if (!ubus_reset_n) begin
            state_q    <= INIT;
            gnt_q      <= '0;
            last_gnt_q <= PTR_W'(NUM_MASTERS - 1);
            start_q    <= 1'b0;
            noop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            start_q    <= start_d;
            noop_q     <= noop_d;
        end
    end

`ifdef UBUS_ARB_WATCHDOG_EN
    localparam int WD_W = UBUS_ARB_WD_CNT_W;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    assign wd_expire = (wd_cnt_q == WD_W'(MAX_WAIT));

    // Counter holds the index of the current DATA cycle, starting at 1.
    always_comb begin
        wd_cnt_d  = '0;
        timeout_d = 1'b0;
        if (state_d == DATA) begin
            wd_cnt_d = (state_q == DATA) ? wd_cnt_q + WD_W'(1) : WD_W'(1);
        end
        if (state_q == DATA && !data_done && wd_expire) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge ubus_clock) begin
        if (!ubus_reset_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ubus_timeout = timeout_q;
`else
    assign wd_expire    = 1'b0;
    assign ubus_timeout = 1'b0;
`endif

    assign ubus_gnt   = gnt_q;
    assign ubus_start = start_q;
    assign ubus_read  = noop_q ? 1'b0 : 1'bz;
    assign ubus_write = noop_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ubus_rr_arbiter.sv
// Bench for ubus_rr_arbiter: vector table, directed corner sequences, then random traffic vs a reference model.
module tb_ubus_rr_arbiter;

    localparam int NM   = 4;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NM-1:0] req;
    logic          bip, wt, err;
    logic [NM-1:0] gnt;
    logic          start, tmo;
    wire           rd, wr;

    int n_chk  = 0;
    int n_pass = 0;

    ubus_rr_arbiter #(
        .NUM_MASTERS (NM),
        .MAX_WAIT    (MAXW)
    ) dut (
        .ubus_clock   (clk),
        .ubus_reset_n (rst_n),
        .ubus_req     (req),
        .ubus_gnt     (gnt),
        .ubus_start   (start),
        .ubus_read    (rd),
        .ubus_write   (wr),
        .ubus_bip     (bip),
        .ubus_wait    (wt),
        .ubus_error   (err),
        .ubus_timeout (tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic [NM-1:0] req;
        logic          e_start;
        logic [NM-1:0] e_gnt;
        logic          e_noop;
    } vec_t;

    vec_t tbl [23];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic exp_out(input string nm, input logic s, input logic [NM-1:0] g, input logic t);
        chk({nm, "_start"}, {31'b0, start}, {31'b0, s});
        chk({nm, "_gnt"}, {28'b0, gnt}, {28'b0, g});
        chk({nm, "_tmo"}, {31'b0, tmo}, {31'b0, t});
    endtask

    task automatic chk_noop_drive(input string nm);
        chk({nm, "_rdwr"}, {30'b0, rd, wr}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; bip = 1'b0; wt = 1'b0; err = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        exp_out("rst_arb", 1'b1, '0, 1'b0);
    endtask

    // Reference model: bus ownership and phase tracked directly from the protocol rules.
    bit m_init, m_arb, m_noop, m_tmo;
    int m_owner, m_dcnt, m_ptr;

    // Winner is the requester at the smallest rotation distance past the last owner.
    function automatic int rr_pick(input logic [NM-1:0] rq, input int ptr);
        int best  = -1;
        int bestd = NM;
        for (int m = 0; m < NM; m++) begin
            if (rq[m]) begin
                int d;
                d = (m - ptr - 1 + 2 * NM) % NM;
                if (d < bestd) begin
                    bestd = d;
                    best  = m;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step(input logic r, input logic [NM-1:0] rq, input logic b, input logic w, input logic e);
        m_tmo = 1'b0;
        if (!r) begin
            m_init = 1'b1; m_arb = 1'b0; m_noop = 1'b0; m_owner = -1; m_ptr = NM - 1;
        end else if (m_init) begin
            m_init = 1'b0; m_arb = 1'b1;
        end else if (m_arb) begin
            m_arb   = 1'b0;
            m_owner = rr_pick(rq, m_ptr);
            if (m_owner < 0) m_noop = 1'b1;
            else begin
                m_ptr  = m_owner;
                m_dcnt = 0;
            end
        end else if (m_noop) begin
            m_noop = 1'b0; m_arb = 1'b1;
        end else if (m_owner >= 0) begin
            if (m_dcnt == 0) m_dcnt = 1;
            else if (e || (!b && !w)) begin
                m_owner = -1; m_arb = 1'b1;
            end
`ifdef UBUS_ARB_WATCHDOG_EN
            else if (m_dcnt == MAXW) begin
                m_owner = -1; m_arb = 1'b1; m_tmo = 1'b1;
            end
`endif
            else m_dcnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; bip = 1'b0; wt = 1'b0; err = 1'b0;

        // Idle alternation, then 4'b1111 held: rotation 0,1,2,3,0 with a dropped request in each DATA.
        tbl[0]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
        tbl[2]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1};
        tbl[4]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0};
        tbl[5]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1};
        tbl[6]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0};
        tbl[7]  = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b0};
        tbl[8]  = '{1'b1, 4'h0, 1'b0, 4'h1, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0};
        tbl[10] = '{1'b1, 4'hF, 1'b0, 4'h2, 1'b0};
        tbl[11] = '{1'b1, 4'h0, 1'b0, 4'h2, 1'b0};
        tbl[12] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0};
        tbl[13] = '{1'b1, 4'hF, 1'b0, 4'h4, 1'b0};
        tbl[14] = '{1'b1, 4'h0, 1'b0, 4'h4, 1'b0};
        tbl[15] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0};
        tbl[16] = '{1'b1, 4'hF, 1'b0, 4'h8, 1'b0};
        tbl[17] = '{1'b1, 4'h0, 1'b0, 4'h8, 1'b0};
        tbl[18] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0};
        tbl[19] = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b0};
        tbl[20] = '{1'b1, 4'h0, 1'b0, 4'h1, 1'b0};
        tbl[21] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0};
        tbl[22] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1};

        for (int i = 0; i < 23; i++) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            cyc();
            exp_out($sformatf("tbl%0d", i), tbl[i].e_start, tbl[i].e_gnt, 1'b0);
            if (tbl[i].e_noop) chk_noop_drive($sformatf("tbl%0d", i));
        end

        // Long burst from master 2: ADDR plus four DATA cycles.
        do_reset();
        req = 4'b0100;
        cyc();
        exp_out("burst_addr", 1'b0, 4'b0100, 1'b0);
        req = '0; bip = 1'b1;
        cyc();
        exp_out("burst_d1", 1'b0, 4'b0100, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            exp_out($sformatf("burst_d%0d", i), 1'b0, 4'b0100, 1'b0);
        end
        bip = 1'b0;
        cyc();
        exp_out("burst_end", 1'b1, '0, 1'b0);
        cyc();
        exp_out("burst_noop", 1'b0, '0, 1'b0);
        chk_noop_drive("burst_noop");

        // Error overrides bip/wait after a single DATA cycle.
        cyc();
        exp_out("err_arb", 1'b1, '0, 1'b0);
        req = 4'b0001;
        cyc();
        exp_out("err_addr", 1'b0, 4'b0001, 1'b0);
        req = '0; bip = 1'b1; wt = 1'b1; err = 1'b1;
        cyc();
        exp_out("err_d1", 1'b0, 4'b0001, 1'b0);
        cyc();
        exp_out("err_exit", 1'b1, '0, 1'b0);
        bip = 1'b0; wt = 1'b0; err = 1'b0;

        // Stuck wait: watchdog abort, or an indefinite hold when the watchdog is absent.
        req = 4'b1000;
        cyc();
        exp_out("wd_addr", 1'b0, 4'b1000, 1'b0);
        req = '0; wt = 1'b1;
`ifdef UBUS_ARB_WATCHDOG_EN
        for (int i = 1; i <= MAXW; i++) begin
            cyc();
            exp_out($sformatf("wd_d%0d", i), 1'b0, 4'b1000, 1'b0);
        end
        cyc();
        exp_out("wd_abort", 1'b1, '0, 1'b1);
        cyc();
        exp_out("wd_after", 1'b0, '0, 1'b0);
        wt = 1'b0;
`else
        for (int i = 1; i <= 100; i++) begin
            cyc();
            exp_out($sformatf("hold_d%0d", i), 1'b0, 4'b1000, 1'b0);
        end
        wt = 1'b0;
        cyc();
        exp_out("hold_exit", 1'b1, '0, 1'b0);
        cyc();
        exp_out("hold_noop", 1'b0, '0, 1'b0);
`endif

        // Exit condition on the MAX_WAIT-th DATA cycle beats the watchdog.
        cyc();
        exp_out("lim_arb", 1'b1, '0, 1'b0);
        req = 4'b1000;
        cyc();
        exp_out("lim_addr", 1'b0, 4'b1000, 1'b0);
        req = '0; wt = 1'b1;
        for (int i = 1; i <= MAXW; i++) begin
            cyc();
            exp_out($sformatf("lim_d%0d", i), 1'b0, 4'b1000, 1'b0);
        end
        wt = 1'b0;
        cyc();
        exp_out("lim_exit", 1'b1, '0, 1'b0);

        // Reset during master 2's DATA phase restores the pointer.
        do_reset();
        req = 4'b0100;
        cyc();
        exp_out("mrst_addr", 1'b0, 4'b0100, 1'b0);
        req = '0; bip = 1'b1;
        cyc();
        exp_out("mrst_data", 1'b0, 4'b0100, 1'b0);
        rst_n = 1'b0;
        cyc();
        exp_out("mrst_init", 1'b0, '0, 1'b0);
        rst_n = 1'b1; bip = 1'b0; req = 4'b0101;
        cyc();
        exp_out("mrst_arb", 1'b1, '0, 1'b0);
        cyc();
        exp_out("mrst_win0", 1'b0, 4'b0001, 1'b0);

        // Random traffic against the reference model, starting from reset.
        for (int i = 0; i < 3000; i++) begin
            rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            req   = NM'($urandom);
            bip   = ($urandom_range(0, 1) == 0);
            wt    = ($urandom_range(0, 2) == 0);
            err   = ($urandom_range(0, 9) == 0);
            cyc();
            model_step(rst_n, req, bip, wt, err);
            exp_out($sformatf("rnd%0d", i), m_arb,
                    (m_owner >= 0) ? NM'(1 << m_owner) : '0, m_tmo);
            if (m_noop) chk_noop_drive($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
